rr_arb_4_1: RTL and testbench

Four-channel round-robin arbiter and output register that generates the 2-bit select for a 4:1 multiplexer of W-bit data. It accepts up to four valid/ready source streams, grants one per cycle in rotating priority, and presents the chosen word with its source index on a single valid/ready output. The data path uses a `mux_4_1` instance driven by the grant, so this block is the select-generating stage directly upstream of the mux.

---
 rtl/rr_arb_pkg.sv | 31 +++
 rtl/mux_4_1.sv | 27 ++
 rtl/rr_arb_4_1.sv | 86 ++++++++
 tb/tb_rr_arb_4_1.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/rr_arb_pkg.sv
// Shared types and the rotating-priority search for the 4-channel round-robin arbiter.
package rr_arb_pkg;

    localparam int N_CH = 4;

    typedef logic [1:0] ch_sel_t;

    typedef struct packed {
        logic    any;
        ch_sel_t idx;
    } gnt_t;

    // Rotate so that ptr lands on bit 0, take the lowest set bit, then add ptr back.
    function automatic gnt_t rr_pick(input logic [N_CH-1:0] req, input ch_sel_t ptr);
        logic [2*N_CH-1:0] dbl;
        logic [N_CH-1:0]   rot;
        gnt_t              g;
        dbl   = {req, req} >> ptr;
        rot   = dbl[N_CH-1:0];
        g.any = 1'b0;
        g.idx = 2'd0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (rot[i]) begin
                g.any = 1'b1;
                g.idx = ptr + ch_sel_t'(i);
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/mux_4_1.sv
// W-bit 4:1 multiplexer steered by a 2-bit channel select.
module mux_4_1
    import rr_arb_pkg::*;
#(
    parameter int W = 4
) (
    input  ch_sel_t        sel,
    input  logic [W-1:0]   d0,
    input  logic [W-1:0]   d1,
    input  logic [W-1:0]   d2,
    input  logic [W-1:0]   d3,
    output logic [W-1:0]   y
);

    // Select one of the four data words.
    always_comb begin
        y = {W{1'b0}};
        case (sel)
            2'd0:    y = d0;
            2'd1:    y = d1;
            2'd2:    y = d2;
            2'd3:    y = d3;
            default: y = {W{1'b0}};
        endcase
    end

endmodule

// File: rtl/rr_arb_4_1.sv
// Four-channel round-robin arbiter feeding a single-entry valid/ready output register.
module rr_arb_4_1
    import rr_arb_pkg::*;
#(
    parameter int W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_CH-1:0]     in_valid,
    input  logic [W-1:0]        in_d0,
    input  logic [W-1:0]        in_d1,
    input  logic [W-1:0]        in_d2,
    input  logic [W-1:0]        in_d3,
    output logic [N_CH-1:0]     in_ready,
    output logic                out_valid,
    output logic [W-1:0]        out_data,
    output ch_sel_t             out_sel,
    input  logic                out_ready
);

    ch_sel_t        ptr_q, ptr_d;
    ch_sel_t        out_sel_q, out_sel_d;
    logic           out_valid_q, out_valid_d;
    logic [W-1:0]   out_data_q, out_data_d;
    logic [W-1:0]   mux_y;
    gnt_t           gnt;
    logic           can_load;
    logic           xfer;

    mux_4_1 #(.W(W)) u_mux (
        .sel (gnt.idx),
        .d0  (in_d0),
        .d1  (in_d1),
        .d2  (in_d2),
        .d3  (in_d3),
        .y   (mux_y)
    );

    // Grant, handshake and next-state for the pointer and output register.
    always_comb begin
        gnt         = rr_pick(in_valid, ptr_q);
        can_load    = !out_valid_q || out_ready;
        in_ready    = 4'b0000;
        ptr_d       = ptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        // Ready is masked during reset, when the cleared register would otherwise accept.
        if (!rst && can_load && gnt.any) begin
            in_ready[gnt.idx] = 1'b1;
        end else begin
            in_ready = 4'b0000;
        end
        xfer = |(in_valid & in_ready);
        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = mux_y;
            out_sel_d   = gnt.idx;
            ptr_d       = gnt.idx + 2'd1;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q       <= 2'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= {W{1'b0}};
            out_sel_q   <= 2'd0;
        end else begin
            ptr_q       <= ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_arb_4_1.sv
// Directed table-driven bench for rr_arb_4_1 plus hand-written reset sequences.
module tb_rr_arb_4_1;

    logic       clk;
    logic       rst;
    logic [3:0] in_valid;
    logic [3:0] in_d0, in_d1, in_d2, in_d3;
    logic [3:0] in_ready;
    logic       out_valid;
    logic [3:0] out_data;
    logic [1:0] out_sel;
    logic       out_ready;

    int n_vec;
    int n_bad;

    typedef struct {
        logic [3:0] iv;
        logic [3:0] d0, d1, d2, d3;
        logic       ordy;
        logic [3:0] e_rdy;
        logic       e_ov;
        logic [3:0] e_data;
        logic [1:0] e_sel;
    } vec_t;

    vec_t tbl [19];

    rr_arb_4_1 #(.W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_d0     (in_d0),
        .in_d1     (in_d1),
        .in_d2     (in_d2),
        .in_d3     (in_d3),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [3:0] iv, input logic [3:0] d0, input logic [3:0] d1,
                                input logic [3:0] d2, input logic [3:0] d3, input logic ordy,
                                input logic [3:0] e_rdy, input logic e_ov, input logic [3:0] e_data,
                                input logic [1:0] e_sel);
        vec_t v;
        v.iv = iv; v.d0 = d0; v.d1 = d1; v.d2 = d2; v.d3 = d3; v.ordy = ordy;
        v.e_rdy = e_rdy; v.e_ov = e_ov; v.e_data = e_data; v.e_sel = e_sel;
        return v;
    endfunction

    task automatic check(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d]: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    // Drive one vector just after a rising edge, check ready, clock it, check registered outputs.
    task automatic apply(input vec_t v, input int idx);
        in_valid  = v.iv;
        in_d0     = v.d0;
        in_d1     = v.d1;
        in_d2     = v.d2;
        in_d3     = v.d3;
        out_ready = v.ordy;
        #1;
        check("in_ready", idx, {4'h0, in_ready}, {4'h0, v.e_rdy});
        @(posedge clk);
        #1;
        check("out_valid", idx, {7'h0, out_valid}, {7'h0, v.e_ov});
        check("out_data", idx, {4'h0, out_data}, {4'h0, v.e_data});
        check("out_sel", idx, {6'h0, out_sel}, {6'h0, v.e_sel});
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        // Single request on ch2, then drain, then pointer at 3 starts the rotation at ch3.
        tbl[0]  = mk(4'b0100, 4'h1, 4'h2, 4'hA, 4'h4, 1'b1, 4'b0100, 1'b1, 4'hA, 2'd2);
        tbl[1]  = mk(4'b0000, 4'h1, 4'h2, 4'h3, 4'h4, 1'b1, 4'b0000, 1'b0, 4'hA, 2'd2);
        tbl[2]  = mk(4'b1111, 4'h1, 4'h2, 4'h3, 4'h4, 1'b1, 4'b1000, 1'b1, 4'h4, 2'd3);
        tbl[3]  = mk(4'b1111, 4'h1, 4'h2, 4'h3, 4'h4, 1'b1, 4'b0001, 1'b1, 4'h1, 2'd0);
        tbl[4]  = mk(4'b1111, 4'h1, 4'h2, 4'h3, 4'h4, 1'b1, 4'b0010, 1'b1, 4'h2, 2'd1);
        tbl[5]  = mk(4'b1111, 4'h1, 4'h2, 4'h3, 4'h4, 1'b1, 4'b0100, 1'b1, 4'h3, 2'd2);
        tbl[6]  = mk(4'b1111, 4'h1, 4'h2, 4'h3, 4'h4, 1'b1, 4'b1000, 1'b1, 4'h4, 2'd3);
        tbl[7]  = mk(4'b1111, 4'h1, 4'h2, 4'h3, 4'h4, 1'b1, 4'b0001, 1'b1, 4'h1, 2'd0);
        // Backpressure for three cycles, then drain-and-load of ch1.
        tbl[8]  = mk(4'b1111, 4'h1, 4'h2, 4'h3, 4'h4, 1'b0, 4'b0000, 1'b1, 4'h1, 2'd0);
        tbl[9]  = mk(4'b1111, 4'h1, 4'h2, 4'h3, 4'h4, 1'b0, 4'b0000, 1'b1, 4'h1, 2'd0);
        tbl[10] = mk(4'b1111, 4'h1, 4'h2, 4'h3, 4'h4, 1'b0, 4'b0000, 1'b1, 4'h1, 2'd0);
        tbl[11] = mk(4'b1111, 4'h1, 4'h2, 4'h3, 4'h4, 1'b1, 4'b0010, 1'b1, 4'h2, 2'd1);
        // Grant ch0 (ptr becomes 1), then ch0+ch3: ch3 wins, wrap, then ch0.
        tbl[12] = mk(4'b0001, 4'h1, 4'h2, 4'h3, 4'h4, 1'b1, 4'b0001, 1'b1, 4'h1, 2'd0);
        tbl[13] = mk(4'b1001, 4'h1, 4'h2, 4'h3, 4'h4, 1'b1, 4'b1000, 1'b1, 4'h4, 2'd3);
        tbl[14] = mk(4'b1001, 4'h1, 4'h2, 4'h3, 4'h4, 1'b1, 4'b0001, 1'b1, 4'h1, 2'd0);
        // Hold with no requests, then drain without load.
        tbl[15] = mk(4'b0000, 4'h1, 4'h2, 4'h3, 4'h4, 1'b0, 4'b0000, 1'b1, 4'h1, 2'd0);
        tbl[16] = mk(4'b0000, 4'h1, 4'h2, 4'h3, 4'h4, 1'b1, 4'b0000, 1'b0, 4'h1, 2'd0);
        // Pointer held at 1 through the drain: ch1 data 5, then ptr 2 searches 2,3,0 and finds ch0.
        tbl[17] = mk(4'b0010, 4'h1, 4'h5, 4'h3, 4'h4, 1'b1, 4'b0010, 1'b1, 4'h5, 2'd1);
        tbl[18] = mk(4'b0001, 4'hC, 4'h5, 4'h3, 4'h4, 1'b1, 4'b0001, 1'b1, 4'hC, 2'd0);

        rst       = 1'b0;
        in_valid  = 4'b0000;
        in_d0     = 4'h1;
        in_d1     = 4'h2;
        in_d2     = 4'h3;
        in_d3     = 4'h4;
        out_ready = 1'b1;

        // Power-up reset asserted between edges with requests pending.
        #2;
        rst      = 1'b1;
        in_valid = 4'b1111;
        #1;
        check("rst_out_valid", 0, {7'h0, out_valid}, 8'h00);
        check("rst_out_data", 0, {4'h0, out_data}, 8'h00);
        check("rst_out_sel", 0, {6'h0, out_sel}, 8'h00);
        check("rst_in_ready", 0, {4'h0, in_ready}, 8'h00);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst      = 1'b0;
        in_valid = 4'b0000;
        @(posedge clk);
        #1;

        for (int i = 0; i < 19; i++) begin
            apply(tbl[i], i);
        end

        // Mid-stream reset discards the held word (0xC) without a clock edge.
        in_valid  = 4'b1111;
        in_d0     = 4'h1;
        out_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", 1, {7'h0, out_valid}, 8'h00);
        check("mid_rst_out_data", 1, {4'h0, out_data}, 8'h00);
        check("mid_rst_out_sel", 1, {6'h0, out_sel}, 8'h00);
        check("mid_rst_in_ready", 1, {4'h0, in_ready}, 8'h00);
        #2;
        rst = 1'b0;
        // First grant after release restarts from ch0.
        apply(mk(4'b1111, 4'h1, 4'h2, 4'h3, 4'h4, 1'b1, 4'b0001, 1'b1, 4'h1, 2'd0), 19);
        apply(mk(4'b1111, 4'h1, 4'h2, 4'h3, 4'h4, 1'b1, 4'b0010, 1'b1, 4'h2, 2'd1), 20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
